dac_sample_monitor: RTL and testbench

- Receive-side counterpart of the waveform generator's 10-bit DAC output bus.
- Consumes the DAC sample stream and measures each waveform cycle: period in samples, minimum code and maximum code.
- Uses a Schmitt-trigger crossing detector around mid-scale and reports one result per rising crossing.
- Used on-chip for self-check and by benches to score generator output automatically.

---
 rtl/dac_sample_monitor.sv | 108 ++++++++++
 tb/tb_dac_sample_monitor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_monitor.sv
// Measures period, min and max code of each waveform cycle on a DAC sample stream,
// using a Schmitt-trigger rising-crossing detector around mid-scale.
//
// state | meaning
// SEEK  | level unknown, waiting for a low sample
// ARMED | low seen, waiting for the first rising crossing
// HI    | measuring, level high
// LO    | measuring, level low; next high sample closes the cycle
`timescale 1ns/1ps
module dac_sample_monitor #(
  parameter int WIDTH   = 10,
  parameter int CNT_W   = 24,
  parameter int MID     = 512,
  parameter int HYST    = 16,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val,
  output logic             locked,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] RISE_TH     = WIDTH'(MID + HYST);
  localparam logic [WIDTH-1:0] FALL_TH     = WIDTH'(MID - HYST);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {SEEK, ARMED, HI, LO} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] run_min;
  logic [WIDTH-1:0] run_max;
  logic             is_hi;
  logic             is_lo;
  logic [CNT_W-1:0] cnt_inc;

  assign is_hi   = (sample >= RISE_TH);
  assign is_lo   = (sample <= FALL_TH);
  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEEK;
      cnt        <= '0;
      run_min    <= '1;
      run_max    <= '0;
      meas_valid <= 1'b0;
      period     <= '0;
      min_val    <= '0;
      max_val    <= '0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (sample_valid) begin
        case (state)
          SEEK: begin
            if (is_lo) state <= ARMED;
          end
          ARMED: begin
            if (is_hi) begin
              state   <= HI;
              locked  <= 1'b1;
              timeout <= 1'b0;
              cnt     <= CNT_W'(1);
              run_min <= sample;
              run_max <= sample;
            end
          end
          HI, LO: begin
            if (state == LO && is_hi) begin
              // Crossing sample closes this cycle and opens the next one.
              state      <= HI;
              meas_valid <= 1'b1;
              period     <= cnt;
              min_val    <= run_min;
              max_val    <= run_max;
              timeout    <= 1'b0;
              cnt        <= CNT_W'(1);
              run_min    <= sample;
              run_max    <= sample;
            end else if (cnt_inc == TIMEOUT_CNT) begin
              state   <= SEEK;
              locked  <= 1'b0;
              timeout <= 1'b1;
              cnt     <= '0;
              run_min <= '1;
              run_max <= '0;
            end else begin
              cnt     <= cnt_inc;
              run_min <= (sample < run_min) ? sample : run_min;
              run_max <= (sample > run_max) ? sample : run_max;
              if (state == HI && is_lo) state <= LO;
            end
          end
          default: state <= SEEK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_sample_monitor.sv
// Scoreboard bench for dac_sample_monitor: expected reports are queued as crossing
// samples are driven and compared when meas_valid pulses.
`timescale 1ns/1ps
module tb_dac_sample_monitor;

  localparam int WIDTH = 10;
  localparam int CNT_W = 24;
  localparam int TMO   = 100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sample_valid = 1'b0;
  logic [WIDTH-1:0] sample = '0;
  logic             meas_valid;
  logic [CNT_W-1:0] period;
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] max_val;
  logic             locked;
  logic             timeout;

  dac_sample_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .meas_valid   (meas_valid),
    .period       (period),
    .min_val      (min_val),
    .max_val      (max_val),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned p;
    int unsigned mn;
    int unsigned mx;
  } meas_t;

  meas_t exp_q[$];
  meas_t e_m;
  int    meas_cyc[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    meas_cnt = 0;
  int    cyc = 0;
  int    lock_exp = -1;
  int    tmo_exp = -1;

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && meas_valid === 1'b1) begin
      meas_cnt++;
      meas_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_val("meas_unexpected", 1, 0);
      end else begin
        e_m = exp_q.pop_front();
        check_val("period", period, e_m.p);
        check_val("min_val", min_val, e_m.mn);
        check_val("max_val", max_val, e_m.mx);
      end
    end
  end

  // One clock per call; invalid cycles carry the opposite code to expose gating faults.
  task automatic put(input logic [WIDTH-1:0] s, input bit v);
    @(negedge clk);
    if (lock_exp >= 0) check_val("locked", locked, lock_exp);
    if (tmo_exp >= 0) check_val("timeout", timeout, tmo_exp);
    sample_valid = v;
    sample       = v ? s : ~s;
  endtask

  task automatic put_g(input logic [WIDTH-1:0] s, input int gap);
    repeat (gap) put(s, 1'b0);
    put(s, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) put('0, 1'b0);
  endtask

  task automatic expect_meas(input int unsigned p, input int unsigned mn, input int unsigned mx);
    meas_t m;
    m.p  = p;
    m.mn = mn;
    m.mx = mx;
    exp_q.push_back(m);
  endtask

  task automatic square_cycle(input bit rep, input int gap);
    repeat (4) put_g(10'd0, gap);
    if (rep) expect_meas(8, 0, 1023);
    repeat (4) put_g(10'd1023, gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_zero_outputs(input string pfx);
    check_val({pfx, "_period"}, period, 0);
    check_val({pfx, "_min_val"}, min_val, 0);
    check_val({pfx, "_max_val"}, max_val, 0);
    check_val({pfx, "_meas_valid"}, meas_valid, 0);
    check_val({pfx, "_locked"}, locked, 0);
    check_val({pfx, "_timeout"}, timeout, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Square wave, valid every cycle
    meas_cnt = 0;
    repeat (4) put(10'd0, 1'b1);
    put(10'd1023, 1'b1);
    lock_exp = 1;
    repeat (3) put(10'd1023, 1'b1);
    for (int k = 1; k < 6; k++) square_cycle(1'b1, 0);
    idle(3);
    lock_exp = -1;
    check_val("sq_meas_count", meas_cnt, 5);
    check_val("sq_pending", exp_q.size(), 0);

    // Square wave, valid every third cycle
    do_reset();
    meas_cnt = 0;
    meas_cyc.delete();
    square_cycle(1'b0, 2);
    for (int k = 0; k < 3; k++) square_cycle(1'b1, 2);
    idle(3);
    check_val("sparse_meas_count", meas_cnt, 3);
    if (meas_cyc.size() >= 3) begin
      for (int i = 1; i < 3; i++) check_val("sparse_spacing", meas_cyc[i] - meas_cyc[i-1], 24);
    end
    check_val("sparse_pending", exp_q.size(), 0);

    // Hysteresis: in-band chatter never crosses
    do_reset();
    meas_cnt = 0;
    put(10'd0, 1'b1);
    lock_exp = 0;
    tmo_exp  = 0;
    for (int i = 0; i < 200; i++) put((i % 2) ? 10'd525 : 10'd500, 1'b1);
    idle(2);
    lock_exp = -1;
    tmo_exp  = -1;
    check_val("hyst_meas_count", meas_cnt, 0);

    // Timeout after 99 non-crossing samples following the lock sample
    do_reset();
    meas_cnt = 0;
    put(10'd0, 1'b1);
    put(10'd1023, 1'b1);
    lock_exp = 1;
    tmo_exp  = 0;
    repeat (99) put(10'd700, 1'b1);
    lock_exp = 0;
    tmo_exp  = 1;
    repeat (4) put(10'd0, 1'b1);
    put(10'd1023, 1'b1);
    lock_exp = 1;
    tmo_exp  = 0;
    repeat (3) put(10'd1023, 1'b1);
    square_cycle(1'b1, 0);
    idle(3);
    lock_exp = -1;
    tmo_exp  = -1;
    check_val("tmo_meas_count", meas_cnt, 1);
    check_val("tmo_pending", exp_q.size(), 0);

    // Ramp 0..992 step 32, wrapping
    do_reset();
    meas_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) begin
        if (k > 0 && i == 17) expect_meas(32, 0, 992);
        put(WIDTH'(32 * i), 1'b1);
      end
    end
    idle(3);
    check_val("ramp_meas_count", meas_cnt, 3);
    check_val("ramp_pending", exp_q.size(), 0);

    // Asynchronous reset mid-period while locked
    do_reset();
    meas_cnt = 0;
    square_cycle(1'b0, 0);
    square_cycle(1'b1, 0);
    put(10'd0, 1'b1);
    put(10'd0, 1'b1);
    @(negedge clk);
    sample_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    square_cycle(1'b0, 0);
    square_cycle(1'b1, 0);
    idle(3);
    check_val("rst_meas_count", meas_cnt, 2);
    check_val("rst_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
